fetch_pc_unit: RTL

Parametrised successor to the program counter for the multi-cycle CPU. Holds the PC and runs a fetch sequencer with a req/ack handshake to instruction memory. It presents the fetched instruction to decode with valid/ready. On a control-FSM write strobe it selects the next PC: sequential, branch, immediate jump or register jump. It also exports the link value and traps misaligned targets.

---
 rtl/fetch_pc_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// Program counter with a fetch sequencer: req/ack fetch from instruction memory,
// valid/ready hand-off to decode, and next-PC selection committed by pc_write.
module fetch_pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               JUMP_WIDTH   = 26,
  parameter int               BRANCH_SHIFT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [WIDTH-1:0]      imem_addr,
  input  logic                  imem_ack,
  input  logic [WIDTH-1:0]      imem_data,
  output logic [WIDTH-1:0]      instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  pc_write,
  input  logic                  jump,
  input  logic                  regorimm,
  input  logic                  branch_taken,
  input  logic [15:0]           branchaddress,
  input  logic [JUMP_WIDTH-1:0] jumpaddress,
  input  logic [WIDTH-1:0]      Reg_rs,
  output logic [WIDTH-1:0]      pcaddress,
  output logic [WIDTH-1:0]      Reg_31,
  output logic                  misaligned
);

  typedef enum logic [1:0] {FETCH, HOLD, EXEC, TRAP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_instr;
  logic             r_instr_valid;
  logic             r_misaligned;
  logic             w_req;

  logic [WIDTH-1:0] w_pc_plus4;
  logic [WIDTH-1:0] w_boff;
  logic [WIDTH-1:0] w_branch_target;
  logic [WIDTH-1:0] w_imm_target;
  logic [WIDTH-1:0] w_next_pc;
  logic             w_next_misal;

  assign w_pc_plus4      = r_pc + WIDTH'(4);
  assign w_boff          = WIDTH'($signed(branchaddress)) <<< BRANCH_SHIFT;
  assign w_branch_target = w_pc_plus4 + w_boff;

  // Immediate jumps keep the upper PC region bits, if any are left above the field.
  generate
    if (WIDTH > JUMP_WIDTH + 2) begin : g_imm_region
      assign w_imm_target = {w_pc_plus4[WIDTH-1:JUMP_WIDTH+2], jumpaddress, 2'b00};
    end else begin : g_imm_full
      assign w_imm_target = {jumpaddress, 2'b00};
    end
  endgenerate

  always_comb begin
    w_next_pc = w_pc_plus4;
    if (jump) begin
      w_next_pc = regorimm ? Reg_rs : w_imm_target;
    end else if (branch_taken) begin
      w_next_pc = w_branch_target;
    end
  end

  assign w_next_misal = |w_next_pc[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    case (r_state)
      FETCH: begin
        w_req = 1'b1;
        if (imem_ack) w_state_nxt = HOLD;
      end
      HOLD:    if (instr_ready) w_state_nxt = EXEC;
      EXEC:    if (pc_write) w_state_nxt = w_next_misal ? TRAP : FETCH;
      TRAP:    w_state_nxt = TRAP;
      default: w_state_nxt = FETCH;
    endcase
  end

  // PC only moves in EXEC, so imem_addr is stable for the whole request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc          <= RESET_VECTOR;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_misaligned  <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (imem_ack) begin
            r_instr       <= imem_data;
            r_instr_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (instr_ready) r_instr_valid <= 1'b0;
        end
        EXEC: begin
          if (pc_write) begin
            r_pc <= w_next_pc;
            if (w_next_misal) r_misaligned <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_req    = w_req;
  assign imem_addr   = r_pc;
  assign pcaddress   = r_pc;
  assign Reg_31      = w_pc_plus4;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign misaligned  = r_misaligned;

endmodule
